// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: records switch words into program memory,
// runs the stored program from PC 0, or issues a single instruction taken
// from the switches. Each fetched instruction is held for the execute stage
// until exec_done.
module instruction_fetch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ext_exec,
   input  logic        rec_req,
   input  logic [2:0]  rec_addr,
   input  logic [11:0] instr_in,
   input  logic        exec_done,
   output logic [2:0]  address,
   output logic        isexternal,
   output logic        record,
   output logic [11:0] instr_out,
   output logic        instr_valid,
   output logic [2:0]  pc,
   output logic        busy,
   output logic        prog_done,
   output logic [3:0]  exec_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REC     = 3'd1,
      REQ     = 3'd2,
      CAPTURE = 3'd3,
      EXEC    = 3'd4,
      NEXT    = 3'd5
   } state_t;

   state_t      state, state_nx;
   logic        ext_q;       // current fetch comes from the switches
   logic [2:0]  rec_addr_q;  // record slot captured when the request is taken
   logic        halt;

   // A halt opcode only ends a stored-program run; external words always execute.
   assign halt = !ext_q && (instr_in[11:9] == 3'b111);

   // State register; reset returns to IDLE at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; requests are only honoured in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (rec_req)       state_nx = REC;
            else if (ext_exec) state_nx = REQ;
            else if (start)    state_nx = REQ;
         end
         REC:     state_nx = IDLE;
         REQ:     state_nx = CAPTURE;
         CAPTURE: state_nx = halt ? IDLE : EXEC;
         EXEC:    if (exec_done) state_nx = NEXT;
         NEXT:    state_nx = (ext_q || pc == 3'd7) ? IDLE : REQ;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers: pc, ext flag, record slot, held instruction, counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= '0;
         ext_q      <= 1'b0;
         rec_addr_q <= '0;
         instr_out  <= '0;
         prog_done  <= 1'b0;
         exec_count <= '0;
      end else begin
         prog_done <= 1'b0;
         case (state)
            IDLE: begin
               if (rec_req) rec_addr_q <= rec_addr;
               else if (ext_exec) ext_q <= 1'b1;
               else if (start) begin
                  pc    <= '0;
                  ext_q <= 1'b0;
               end
            end
            CAPTURE: begin
               instr_out <= instr_in;
               if (halt) begin
                  pc        <= '0;
                  prog_done <= 1'b1;
               end
            end
            EXEC: if (exec_done) exec_count <= exec_count + 4'd1;
            NEXT: begin
               if (ext_q) ext_q <= 1'b0;
               else if (pc == 3'd7) begin
                  pc        <= '0;
                  prog_done <= 1'b1;
               end else pc <= pc + 3'd1;
            end
            default: ;
         endcase
      end
   end

   // Memory-side and status outputs decoded from the current state and registers.
   always_comb begin
      address     = (state == REC) ? rec_addr_q : pc;
      record      = (state == REC);
      isexternal  = ext_q && (state == REQ || state == CAPTURE);
      instr_valid = (state == EXEC);
      busy        = (state != IDLE);
   end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: a registered program memory model drives
// instr_in, a transaction-level reference (memory copy, pc, completion count)
// predicts each issued word, plus vector table, directed corner sequences
// and randomized record/ext/run operations.
module tb_instruction_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, ext_exec = 1'b0, rec_req = 1'b0, exec_done = 1'b0;
   logic [2:0]  rec_addr = '0;
   logic [11:0] instr_in = '0, sw = '0;
   logic [2:0]  address, pc;
   logic        isexternal, record, instr_valid, busy, prog_done;
   logic [11:0] instr_out;
   logic [3:0]  exec_count;

   int tests = 0, fails = 0;

   instruction_fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .ext_exec(ext_exec), .rec_req(rec_req),
      .rec_addr(rec_addr), .instr_in(instr_in), .exec_done(exec_done),
      .address(address), .isexternal(isexternal), .record(record),
      .instr_out(instr_out), .instr_valid(instr_valid), .pc(pc), .busy(busy),
      .prog_done(prog_done), .exec_count(exec_count)
   );

   always #5 clk = ~clk;

   // Program memory with registered read; switches selected by isexternal.
   logic [11:0] mem [8] = '{12'h481, 12'h6C1, 12'hC07, 12'h904, 12'hC07, 12'hB04, 12'hC07, 12'hE00};
   always @(posedge clk) begin
      if (record) mem[address] <= sw;
      instr_in <= isexternal ? sw : mem[address];
   end

   // Reference model state.
   logic [11:0] ref_mem [8] = '{12'h481, 12'h6C1, 12'hC07, 12'h904, 12'hC07, 12'hB04, 12'hC07, 12'hE00};
   logic [3:0]  ref_count = '0;
   logic [2:0]  ref_pc = '0;

   typedef struct {
      logic [11:0] sw;
      int          dly;
      logic [11:0] exp_instr;
      logic [3:0]  exp_cnt;
   } vec_t;
   vec_t tv [6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_address"}, address, 0);
      chk({nm, "_isext"}, isexternal, 0);
      chk({nm, "_record"}, record, 0);
      chk({nm, "_instr_out"}, instr_out, 0);
      chk({nm, "_valid"}, instr_valid, 0);
      chk({nm, "_pc"}, pc, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_prog_done"}, prog_done, 0);
      chk({nm, "_count"}, exec_count, 0);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #3;
      rst = 1'b0;
      ref_count = '0;
      ref_pc = '0;
      tick;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (instr_valid) begin ok = 1'b1; return; end
         tick;
      end
      timeout("wait_instr_valid");
   endtask

   task automatic issue(input logic [11:0] exp, input int dly);
      bit ok;
      wait_valid(ok);
      if (!ok) return;
      chk("instr_out", instr_out, exp);
      for (int k = 0; k < dly; k++) begin
         tick;
         chk("hold_valid", instr_valid, 1);
         chk("hold_instr", instr_out, exp);
      end
      exec_done = 1'b1;
      tick;
      exec_done = 1'b0;
      ref_count++;
      chk("valid_drop", instr_valid, 0);
      chk("exec_count", exec_count, ref_count);
   endtask

   task automatic do_rec(input logic [2:0] a, input logic [11:0] w);
      sw = w; rec_addr = a; rec_req = 1'b1;
      tick;
      rec_req = 1'b0;
      chk("rec_record", record, 1);
      chk("rec_address", address, a);
      chk("rec_isext", isexternal, 0);
      tick;
      chk("rec_record_off", record, 0);
      chk("rec_idle", busy, 0);
      chk("rec_pc", pc, ref_pc);
      ref_mem[a] = w;
   endtask

   task automatic do_ext(input logic [11:0] w, input int dly);
      sw = w; ext_exec = 1'b1;
      tick;
      ext_exec = 1'b0;
      chk("ext_isext", isexternal, 1);
      chk("ext_address", address, ref_pc);
      issue(w, dly);
      tick;
      chk("ext_idle", busy, 0);
      chk("ext_pc", pc, ref_pc);
   endtask

   // Stored program: words from slot 0 up to (not including) the first halt,
   // at most eight; run always ends with pc back at 0 and a prog_done pulse.
   task automatic run_prog(input int dly);
      logic [11:0] q [$];
      bit seen;
      for (int i = 0; i < 8; i++) begin
         if (ref_mem[i][11:9] == 3'b111) break;
         q.push_back(ref_mem[i]);
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      foreach (q[i]) issue(q[i], dly);
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         if (prog_done) seen = 1'b1;
         else tick;
      end
      if (!seen) timeout("prog_done");
      ref_pc = '0;
      chk("prog_pc", pc, ref_pc);
      chk("prog_busy", busy, 0);
      chk("prog_count", exec_count, ref_count);
      tick;
      chk("prog_done_pulse", prog_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      tv[0] = '{12'h6C1, 2, 12'h6C1, 4'd1};
      tv[1] = '{12'hE00, 0, 12'hE00, 4'd2};   // halt opcode still executes when external
      tv[2] = '{12'hFFF, 1, 12'hFFF, 4'd3};
      tv[3] = '{12'h000, 3, 12'h000, 4'd4};
      tv[4] = '{12'h5A5, 0, 12'h5A5, 4'd5};
      tv[5] = '{12'hDFF, 2, 12'hDFF, 4'd6};

      // Reset state
      rst = 1'b1;
      #3;
      chk_zero("reset");
      rst = 1'b0;
      tick;

      // Latency: pulse driven, instr_valid after the third edge
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("lat_req_busy", busy, 1);
      chk("lat_req_valid", instr_valid, 0);
      tick;
      chk("lat_cap_valid", instr_valid, 0);
      tick;
      chk("lat_exec_valid", instr_valid, 1);
      chk("lat_instr", instr_out, 12'h481);
      // Asynchronous reset mid-EXEC, between edges
      #3 rst = 1'b1;
      #1 chk_zero("rst_exec");
      #2 rst = 1'b0;
      tick;
      chk("rst_exec_idle", busy, 0);
      // Reset mid-fetch abandons the instruction
      start = 1'b1;
      tick;
      start = 1'b0;
      #3 rst = 1'b1;
      #1 chk_zero("rst_fetch");
      #2 rst = 1'b0;
      repeat (4) tick;
      chk("rst_fetch_count", exec_count, 0);
      chk("rst_fetch_busy", busy, 0);
      ref_count = '0; ref_pc = '0;

      // Default program
      do_reset;
      run_prog(2);
      chk("default_count", exec_count, 7);
      chk("default_pc", pc, 0);

      // External execution vectors (count from reset)
      do_reset;
      for (int i = 0; i < 6; i++) begin
         sw = tv[i].sw; ext_exec = 1'b1;
         tick;
         ext_exec = 1'b0;
         chk("tv_isext", isexternal, 1);
         wait_valid(ok);
         if (ok) begin
            chk("tv_instr", instr_out, tv[i].exp_instr);
            repeat (tv[i].dly) tick;
            exec_done = 1'b1;
            tick;
            exec_done = 1'b0;
            chk("tv_count", exec_count, tv[i].exp_cnt);
            tick;
            chk("tv_idle", busy, 0);
            chk("tv_pc", pc, 0);
         end
      end

      // Record slot 3, then run the program
      do_reset;
      do_rec(3'd3, 12'hABC);
      run_prog(1);

      // rec_req and start together: record wins, start dropped
      sw = 12'h555; rec_addr = 3'd5; rec_req = 1'b1; start = 1'b1;
      tick;
      rec_req = 1'b0; start = 1'b0;
      chk("both_record", record, 1);
      chk("both_address", address, 5);
      tick;
      chk("both_idle", busy, 0);
      tick;
      chk("both_no_start", busy, 0);
      ref_mem[5] = 12'h555;

      // Long hold in EXEC with requests pulsed in the middle
      sw = 12'h123; ext_exec = 1'b1;
      tick;
      ext_exec = 1'b0;
      wait_valid(ok);
      if (ok) begin
         for (int i = 0; i < 20; i++) begin
            if (i == 5) begin start = 1'b1; rec_req = 1'b1; ext_exec = 1'b1; end
            tick;
            start = 1'b0; rec_req = 1'b0; ext_exec = 1'b0;
            chk("hold20_valid", instr_valid, 1);
            chk("hold20_instr", instr_out, 12'h123);
            chk("hold20_record", record, 0);
         end
         exec_done = 1'b1;
         tick;
         exec_done = 1'b0;
         ref_count++;
         chk("hold20_drop", instr_valid, 0);
         chk("hold20_count", exec_count, ref_count);
         tick;
         chk("hold20_idle", busy, 0);
         chk("hold20_pc", pc, ref_pc);
      end

      // Randomized operations against the reference model
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: do_rec(3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
            1: do_ext(12'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
            default: run_prog(int'($urandom_range(0, 3)));
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
